// File: rtl/rfsoc_regs_pkg.sv
// Shared types and register map for the multi-channel RFSoC datamover register bank.
// Holds the channel run-state encoding, per-channel and global register offsets,
// and a byte-strobe expansion helper.
package rfsoc_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    // Encoding is visible to software in status[5:4]
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } chn_state_t;

    // Offsets inside one channel window
    localparam logic [15:0] OFS_ADDR = 16'h0000;
    localparam logic [15:0] OFS_SIZE = 16'h0004;
    localparam logic [15:0] OFS_CTRL = 16'h0008;
    localparam logic [15:0] OFS_STAT = 16'h000C;
    localparam logic [15:0] OFS_CYC  = 16'h0010;

    // Offsets inside the global window
    localparam logic [15:0] OFS_IRQ_EN = 16'h0000;
    localparam logic [15:0] OFS_IRQ_ST = 16'h0004;
    localparam logic [15:0] OFS_VER    = 16'h0008;
    localparam logic [15:0] OFS_NCHN   = 16'h000C;

    // Expand byte enables into a bit mask
    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < int'(STRB_W); b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/rfsoc_chn_ctrl.sv
// One channel of the register bank: shadow/active address and size, ctrl bits,
// run FSM, saturating run-cycle counter and sticky done/err/overrun flags.
// Ports: clk/rstb; decoded write strobes wr_addr/wr_size/wr_ctrl with wdata/wstrb;
// engine pulses done_in/err_in; register outputs for readback and engine control.
module rfsoc_chn_ctrl
    import rfsoc_regs_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_addr,
    input  logic              wr_size,
    input  logic              wr_ctrl,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              done_in,
    input  logic              err_in,
    output logic [DATA_W-1:0] shadow_addr,
    output logic [DATA_W-1:0] shadow_size,
    output logic [DATA_W-1:0] active_addr,
    output logic [DATA_W-1:0] active_size,
    output logic              start,
    output logic              soft_reset,
    output logic              cont,
    output chn_state_t        state,
    output logic              done_flag,
    output logic              err_flag,
    output logic              overrun,
    output logic [DATA_W-1:0] run_cycles
);

    chn_state_t        state_nxt;
    logic              load_c;
    logic              clr_c;
    logic              ovr_c;
    logic              done_c;
    logic              err_c;
    logic              start_req_c;
    logic              reset_req_c;
    logic [DATA_W-1:0] wmask_c;

    assign wmask_c     = strb_mask(wstrb);
    assign start_req_c = wr_ctrl && wdata[0];
    // A write that raises RESET also suppresses a START carried in the same word
    assign reset_req_c = wr_ctrl && wstrb[0] && wdata[1];

    // Run state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load/flag decisions
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        clr_c     = 1'b0;
        ovr_c     = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
        if (soft_reset) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_req_c && !reset_req_c) begin
                        state_nxt = RUN;
                        load_c    = 1'b1;
                        clr_c     = 1'b1;
                    end
                end
                RUN: begin
                    if (start_req_c) begin
                        ovr_c = 1'b1;
                    end
                    if (err_in) begin
                        state_nxt = ERR;
                        err_c     = 1'b1;
                    end else if (done_in) begin
                        done_c = 1'b1;
                        if (cont) begin
                            load_c = 1'b1;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shadow_addr <= '0;
            shadow_size <= '0;
            active_addr <= '0;
            active_size <= '0;
            start       <= 1'b0;
            soft_reset  <= 1'b0;
            cont        <= 1'b0;
            done_flag   <= 1'b0;
            err_flag    <= 1'b0;
            overrun     <= 1'b0;
            run_cycles  <= '0;
        end else begin
            start <= load_c;
            if (load_c) begin
                active_addr <= shadow_addr;
                active_size <= shadow_size;
            end
            if (wr_addr) begin
                shadow_addr <= (shadow_addr & ~wmask_c) | (wdata & wmask_c);
            end
            if (wr_size) begin
                shadow_size <= (shadow_size & ~wmask_c) | (wdata & wmask_c);
            end
            if (wr_ctrl && wstrb[0]) begin
                soft_reset <= wdata[1];
                cont       <= wdata[2];
            end
            if (clr_c) begin
                run_cycles <= '0;
            end else if (state == RUN && run_cycles != '1) begin
                run_cycles <= run_cycles + DATA_W'(1);
            end
            if (clr_c) begin
                done_flag <= 1'b0;
                err_flag  <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (done_c) done_flag <= 1'b1;
                if (err_c)  err_flag  <= 1'b1;
                if (ovr_c)  overrun   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rfsoc_chn_regs.sv
// Multi-channel control/status register bank on an AXI-lite slave decode.
// Ports: clk/rstb; wren/rden/offset/wdata/wstrb register access; rdata/rvalid
// registered read return; per-channel chn_start_addr/chn_cap_size/chn_start/chn_reset
// to the engines, chn_done/chn_err from them; irq level interrupt.
module rfsoc_chn_regs
    import rfsoc_regs_pkg::*;
#(
    parameter int unsigned NUM_CHN    = 4,
    parameter logic [15:0] CHN_STRIDE = 16'h0020,
    parameter logic [15:0] GLB_BASE   = 16'h0400,
    parameter logic [31:0] VERSION    = 32'h0002_0000
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      wren,
    input  logic                      rden,
    input  logic [15:0]               offset,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [STRB_W-1:0]         wstrb,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic [32*NUM_CHN-1:0]     chn_start_addr,
    output logic [32*NUM_CHN-1:0]     chn_cap_size,
    output logic [NUM_CHN-1:0]        chn_start,
    output logic [NUM_CHN-1:0]        chn_reset,
    input  logic [NUM_CHN-1:0]        chn_done,
    input  logic [NUM_CHN-1:0]        chn_err,
    output logic                      irq
);

    localparam logic [31:0] CHN_BITS = 32'((64'd1 << NUM_CHN) - 64'd1);
    localparam logic [31:0] IRQ_MASK = CHN_BITS | (CHN_BITS << 16);

    logic [15:0]                     off_al;
    logic                            unused_ofs;
    logic [NUM_CHN-1:0][DATA_W-1:0]  chn_rd;
    logic [DATA_W-1:0]               rd_mux_c;
    logic [DATA_W-1:0]               wmask_c;
    logic [DATA_W-1:0]               hw_set_c;
    logic [DATA_W-1:0]               irq_en;
    logic [DATA_W-1:0]               irq_st;
    logic                            wr_irq_en;
    logic                            wr_irq_st;

    assign off_al     = {offset[15:2], 2'b00};
    assign unused_ofs = ^offset[1:0];
    assign wmask_c    = strb_mask(wstrb);
    assign wr_irq_en  = wren && (off_al == GLB_BASE + OFS_IRQ_EN);
    assign wr_irq_st  = wren && (off_al == GLB_BASE + OFS_IRQ_ST);

    // Per-channel decode, controller and readback
    for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
        localparam logic [15:0] BASE = 16'(c * CHN_STRIDE);

        logic [DATA_W-1:0] shd_addr;
        logic [DATA_W-1:0] shd_size;
        logic [DATA_W-1:0] cycles;
        logic              cont;
        logic              dn;
        logic              er;
        logic              ovr;
        chn_state_t        st;

        rfsoc_chn_ctrl u_ctrl (
            .clk         (clk),
            .rstb        (rstb),
            .wr_addr     (wren && (off_al == BASE + OFS_ADDR)),
            .wr_size     (wren && (off_al == BASE + OFS_SIZE)),
            .wr_ctrl     (wren && (off_al == BASE + OFS_CTRL)),
            .wdata       (wdata),
            .wstrb       (wstrb),
            .done_in     (chn_done[c]),
            .err_in      (chn_err[c]),
            .shadow_addr (shd_addr),
            .shadow_size (shd_size),
            .active_addr (chn_start_addr[32*c +: 32]),
            .active_size (chn_cap_size[32*c +: 32]),
            .start       (chn_start[c]),
            .soft_reset  (chn_reset[c]),
            .cont        (cont),
            .state       (st),
            .done_flag   (dn),
            .err_flag    (er),
            .overrun     (ovr),
            .run_cycles  (cycles)
        );

        assign chn_rd[c] =
            (off_al == BASE + OFS_ADDR) ? shd_addr :
            (off_al == BASE + OFS_SIZE) ? shd_size :
            (off_al == BASE + OFS_CTRL) ? {29'd0, cont, chn_reset[c], 1'b0} :
            (off_al == BASE + OFS_STAT) ? {26'd0, st, ovr, er, dn, (st == RUN)} :
            (off_al == BASE + OFS_CYC)  ? cycles : '0;
    end

    // Hardware set vector in irq bit layout
    always_comb begin
        hw_set_c = '0;
        hw_set_c[NUM_CHN-1:0]  = chn_done;
        hw_set_c[16 +: NUM_CHN] = chn_err;
    end

    // Interrupt enable and W1C status; a hardware set beats a same-cycle clear
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            irq_en <= '0;
            irq_st <= '0;
        end else begin
            if (wr_irq_en) begin
                irq_en <= ((irq_en & ~wmask_c) | (wdata & wmask_c)) & IRQ_MASK;
            end
            irq_st <= ((irq_st & ~(wr_irq_st ? (wdata & wmask_c) : '0)) | hw_set_c) & IRQ_MASK;
        end
    end

    assign irq = |(irq_st & irq_en);

    // Read mux; channel windows never overlap so their readbacks can be OR-ed
    always_comb begin
        rd_mux_c = '0;
        for (int c = 0; c < int'(NUM_CHN); c++) begin
            rd_mux_c = rd_mux_c | chn_rd[c];
        end
        if (off_al == GLB_BASE + OFS_IRQ_EN) rd_mux_c = irq_en;
        if (off_al == GLB_BASE + OFS_IRQ_ST) rd_mux_c = irq_st;
        if (off_al == GLB_BASE + OFS_VER)    rd_mux_c = VERSION;
        if (off_al == GLB_BASE + OFS_NCHN)   rd_mux_c = 32'(NUM_CHN);
    end

    // Registered read return; rdata holds between reads
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rden;
            if (rden) begin
                rdata <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_rfsoc_chn_regs.sv
// Directed self-checking bench for rfsoc_chn_regs with hand-computed expectations.
module tb_rfsoc_chn_regs;

    localparam int NC = 4;

    logic            clk;
    logic            rstb;
    logic            wren;
    logic            rden;
    logic [15:0]     offset;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic [31:0]     rdata;
    logic            rvalid;
    logic [32*NC-1:0] chn_start_addr;
    logic [32*NC-1:0] chn_cap_size;
    logic [NC-1:0]   chn_start;
    logic [NC-1:0]   chn_reset;
    logic [NC-1:0]   chn_done;
    logic [NC-1:0]   chn_err;
    logic            irq;

    int n_cmp;
    int n_bad;
    int start_cnt [NC];
    int snap;

    rfsoc_chn_regs dut (
        .clk            (clk),
        .rstb           (rstb),
        .wren           (wren),
        .rden           (rden),
        .offset         (offset),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .rdata          (rdata),
        .rvalid         (rvalid),
        .chn_start_addr (chn_start_addr),
        .chn_cap_size   (chn_cap_size),
        .chn_start      (chn_start),
        .chn_reset      (chn_reset),
        .chn_done       (chn_done),
        .chn_err        (chn_err),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each start pulse
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (chn_start[c]) start_cnt[c] = start_cnt[c] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Callers are at a falling edge; the access is captured on the next rising edge
    task automatic wr(input logic [15:0] ofs, input logic [31:0] d, input logic [3:0] s);
        wren   = 1'b1;
        offset = ofs;
        wdata  = d;
        wstrb  = s;
        @(negedge clk);
        wren   = 1'b0;
        wstrb  = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [15:0] ofs, input logic [31:0] exp);
        rden   = 1'b1;
        offset = ofs;
        @(negedge clk);
        rden   = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rstb     = 1'b0;
        wren     = 1'b0;
        rden     = 1'b0;
        offset   = '0;
        wdata    = '0;
        wstrb    = '0;
        chn_done = '0;
        chn_err  = '0;
        idle(3);

        // Reset values
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_start", 32'(chn_start), 32'd0);
        check("rst_creset", 32'(chn_reset), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rstb = 1'b1;
        idle(1);

        rd("ctrl0", 16'h0008, 32'd0);
        check("rvalid_drop", 32'(rvalid), 32'd1);
        idle(1);
        check("rvalid_low", 32'(rvalid), 32'd0);
        rd("stat0", 16'h000C, 32'd0);
        rd("version", 16'h0408, 32'h0002_0000);
        rd("num_chn", 16'h040C, 32'd4);
        wr(16'h0300, 32'hFFFF_FFFF, 4'hF);
        rd("unmapped", 16'h0300, 32'd0);

        // Ch1 byte-strobed shadow writes and start
        wr(16'h0020, 32'h1000_0000, 4'b0011);
        rd("ch1_shd_addr", 16'h0020, 32'h0000_0000);
        wr(16'h0024, 32'hDEAD_BEEF, 4'hF);
        wr(16'h0024, 32'h1111_2222, 4'b1100);
        rd("ch1_shd_size", 16'h0024, 32'h1111_BEEF);
        snap = start_cnt[1];
        wr(16'h0028, 32'h1, 4'hF);
        check("ch1_start_now", 32'(chn_start), 32'h2);
        check("ch1_act_addr", chn_start_addr[63:32], 32'h0000_0000);
        check("ch1_act_size", chn_cap_size[63:32], 32'h1111_BEEF);
        idle(3);
        check("ch1_one_pulse", 32'(start_cnt[1] - snap), 32'd1);
        rd("ch1_stat", 16'h002C, 32'h11);
        rd("ch1_ctrl", 16'h0028, 32'h0);

        // Ch0 overrun, done, irq and W1C priority
        wr(16'h0004, 32'h0000_0100, 4'hF);
        wr(16'h0000, 32'h4000_0000, 4'hF);
        wr(16'h0008, 32'h1, 4'hF);
        check("ch0_act_addr", chn_start_addr[31:0], 32'h4000_0000);
        idle(2);
        snap = start_cnt[0];
        wr(16'h0008, 32'h1, 4'hF);
        idle(3);
        check("ch0_no_pulse", 32'(start_cnt[0] - snap), 32'd0);
        rd("ch0_stat_ovr", 16'h000C, 32'h19);
        chn_done = 4'b0001;
        idle(1);
        chn_done = 4'b0000;
        rd("ch0_stat_done", 16'h000C, 32'h2A);
        rd("irq_st_d0", 16'h0404, 32'h1);
        check("irq_masked", 32'(irq), 32'd0);
        wr(16'h0400, 32'h1, 4'hF);
        check("irq_enabled", 32'(irq), 32'd1);
        chn_done = 4'b0001;
        wr(16'h0404, 32'h1, 4'hF);
        chn_done = 4'b0000;
        rd("w1c_vs_set", 16'h0404, 32'h1);
        wr(16'h0404, 32'h1, 4'hF);
        rd("w1c_clear", 16'h0404, 32'h0);
        check("irq_cleared", 32'(irq), 32'd0);

        // Ch2 continuous mode reload
        wr(16'h0040, 32'h0000_5000, 4'hF);
        wr(16'h0048, 32'h5, 4'hF);
        check("ch2_act_addr", chn_start_addr[95:64], 32'h0000_5000);
        wr(16'h0040, 32'h0000_A000, 4'hF);
        idle(1);
        check("ch2_act_held", chn_start_addr[95:64], 32'h0000_5000);
        snap = start_cnt[2];
        chn_done = 4'b0100;
        idle(1);
        chn_done = 4'b0000;
        check("ch2_restart", 32'(chn_start), 32'h4);
        check("ch2_reload", chn_start_addr[95:64], 32'h0000_A000);
        idle(2);
        check("ch2_one_pulse", 32'(start_cnt[2] - snap), 32'd1);
        rd("ch2_stat", 16'h004C, 32'h13);

        // Ch3 simultaneous err and done
        wr(16'h0068, 32'h1, 4'hF);
        chn_err  = 4'b1000;
        chn_done = 4'b1000;
        idle(1);
        chn_err  = 4'b0000;
        chn_done = 4'b0000;
        rd("ch3_stat", 16'h006C, 32'h34);
        rd("irq_st_mix", 16'h0404, 32'h0008_000C);
        check("irq_off", 32'(irq), 32'd0);
        wr(16'h0400, 32'h0008_0000, 4'hF);
        check("irq_err_en", 32'(irq), 32'd1);

        // Ch1 soft reset blocks start
        wr(16'h0028, 32'h2, 4'hF);
        check("ch1_creset", 32'(chn_reset), 32'h2);
        idle(1);
        rd("ch1_stat_rst", 16'h002C, 32'h0);
        snap = start_cnt[1];
        wr(16'h0028, 32'h3, 4'hF);
        idle(3);
        check("ch1_start_blk", 32'(start_cnt[1] - snap), 32'd0);
        rd("ch1_ctrl_rst", 16'h0028, 32'h2);
        wr(16'h0028, 32'h0, 4'hF);
        check("ch1_creset_off", 32'(chn_reset), 32'h0);

        // Ch0 run_cycles restart and saturation
        wr(16'h0008, 32'h1, 4'hF);
        rd("cyc_clear", 16'h0010, 32'd0);
        rd("cyc_one", 16'h0010, 32'd1);
        force dut.g_chn[0].u_ctrl.run_cycles = 32'hFFFF_FFFD;
        idle(1);
        release dut.g_chn[0].u_ctrl.run_cycles;
        idle(6);
        rd("cyc_sat", 16'h0010, 32'hFFFF_FFFF);
        rd("cyc_sat_hold", 16'h0010, 32'hFFFF_FFFF);

        // Reset asserted while channels run
        rstb = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            check("mid_rst_addr", chn_start_addr[32*c +: 32], 32'd0);
            check("mid_rst_size", chn_cap_size[32*c +: 32], 32'd0);
        end
        check("mid_rst_start", 32'(chn_start), 32'd0);
        check("mid_rst_creset", 32'(chn_reset), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        idle(2);
        rstb = 1'b1;
        idle(1);
        rd("post_rst_stat0", 16'h000C, 32'd0);
        rd("post_rst_shd2", 16'h0040, 32'd0);
        rd("post_rst_irq_en", 16'h0400, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rfsoc_chn_regs.md
# rfsoc_chn_regs

Parametrised control/status register bank for NUM_CHN independent capture/playback channels (DAC/ADC datamover engines). Sits on the AXI-lite slave decode, like the single-channel register block it supersedes. It adds several behaviours:
- per-channel run state machine with self-clearing start pulses;
- shadow/active address copies latched at start;
- saturating run-cycle counters;
- per-channel write-1-to-clear interrupts;
- registered read path with a valid strobe.

## Interface
Parameters:
- NUM_CHN, 4, number of channels (1..16)
- CHN_STRIDE, 16'h0020, byte stride between channel register windows starting at 0x0000
- GLB_BASE, 16'h0400, base of global registers
- VERSION, 32'h0002_0000, value returned by the version register

Ports:
- clk  in  1  register clock
- rstb  in  1  reset; asynchronous and active-low, all flops cleared
- wren  in  1  write strobe, one cycle per write
- rden  in  1  read strobe, one cycle per read
- offset  in  16  byte offset; bits [1:0] ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- rdata  out  32  read data
- rvalid  out  1  read data valid pulse
- chn_start_addr  out  32*NUM_CHN  active start address per channel
- chn_cap_size  out  32*NUM_CHN  active transfer size per channel
- chn_start  out  NUM_CHN  one-cycle start pulse
- chn_reset  out  NUM_CHN  level soft reset
- chn_done  in  NUM_CHN  one-cycle completion pulse from engine
- chn_err  in  NUM_CHN  one-cycle error pulse from engine
- irq  out  1  level interrupt

## Operation
Channel window at c*CHN_STRIDE:
- +0x00: shadow start address, RW, byte-strobed
- +0x04: shadow size, RW, byte-strobed
- +0x08: ctrl
  - [0] START: W1S, reads 0
  - [1] RESET: RW level, needs wstrb[0]
  - [2] CONT: RW, needs wstrb[0]
- +0x0C: status RO
  - [0] busy, [1] done, [2] err, [3] overrun
  - [5:4] state encoding
- +0x10: run_cycles RO

Global window:
- GLB_BASE+0x0: irq_enable, RW
  - [NUM_CHN-1:0] done enables
  - [16+NUM_CHN-1:16] err enables
- GLB_BASE+0x4: irq_status, W1C, same bit layout
- GLB_BASE+0x8: VERSION, RO
- GLB_BASE+0xC: NUM_CHN, RO

Any other offset reads 0; writes to it are ignored.

Per-channel FSM:
- IDLE → RUN on START when RESET=0. Shadow addr/size are copied to the active outputs and chn_start pulses. run_cycles clears to 0, and done/err/overrun clear.
- RUN → DONE on chn_done. If CONT=1, it instead re-enters RUN: active copies reload from shadow, chn_start pulses again, run_cycles does not clear.
- RUN → ERR on chn_err. chn_err wins over a simultaneous chn_done.
- DONE/ERR → RUN on START.
- Any state → IDLE while RESET=1. START is ignored while RESET=1, and the active copies are held.

Boundary rules:
- START while in RUN: ignored, sets overrun (sticky until next accepted START).
- Shadow writes while RUN: accepted; the active outputs are unchanged until the next load.
- run_cycles: increments every cycle in RUN and saturates at 32'hFFFF_FFFF.

Interrupts:
- irq_status done bit c is set on chn_done[c]; err bit c is set on chn_err[c].
- If a hardware set and a W1C clear of the same bit occur in one cycle, set wins.
- irq = |(irq_status & irq_enable). Enabling an already-set bit asserts irq.

## Timing
- Write: registers update on the clk edge where wren=1. chn_start asserts the cycle after the START write, exactly one cycle wide.
- Read: rdata and rvalid are registered. rdata is valid, with rvalid=1, one cycle after rden. rdata holds until the next read.
- chn_done/chn_err affect status and irq_status one cycle after the input pulse. irq follows combinationally from those registered bits.
- Reset values: rdata=0, rvalid=0, chn_start=0, chn_reset=0, all active copies 0, irq=0, FSM=IDLE.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at reset values.

## Structure
- Package rfsoc_regs_pkg holds:
  - state enum chn_state_t {IDLE, RUN, DONE, ERR};
  - channel register offset localparams (OFS_ADDR, OFS_SIZE, OFS_CTRL, OFS_STAT, OFS_CYC);
  - global offset localparams.
- One sub-module, rfsoc_chn_ctrl, instantiated NUM_CHN times via generate. It contains the shadow/active registers, FSM, counter and sticky bits. The top level owns address decode, the irq registers and the read mux.

## Test plan
- Reset, then read 0x0008, 0x000C, GLB_BASE+0x8 → 0, 0, 32'h0002_0000, each with rvalid one cycle after rden.
- Ch1: write 0x20=32'h1000_0000 with wstrb=4'b0011, then 0x28=1 → active addr 32'h0000_0000 shows the byte mask; exactly one chn_start[1] pulse; status busy=1.
- Ch0 in RUN with START rewritten → no pulse, overrun=1. Then chn_done[0] → done=1, irq_status[0]=1; irq=1 only after irq_enable[0]=1. W1C in the same cycle as a new chn_done keeps the bit set.
- CONT=1 on ch2, change shadow addr mid-RUN to 32'hA000, pulse chn_done[2] → chn_start[2] re-pulses and active addr becomes 32'hA000.
- chn_err[3] and chn_done[3] in the same cycle → state ERR, err bit set, done bit clear in status.
- Force run_cycles near saturation (long RUN) → stays 32'hFFFF_FFFF. Assert rstb low mid-RUN → all outputs 0, FSM IDLE.
